izh_neuron_array: RTL and testbench
===================================

// Module: izh_neuron_array
// PURPOSE
// - Time-multiplexed array of N_NEURONS Izhikevich neurons sharing one saturating signed fixed-point datapath.
// - Per-neuron v/u state and input current held in internal register arrays; one neuron updated per clock during a sweep.
// - A sweep is one simulation step for every neuron, started by step and closed by a done pulse with the spike vector.
// - Successor to the single-neuron izh core: parametrised width, format and count, saturating maths, handshake.
// PARAMETERS
// - N_NEURONS  4       neurons in array (>=1); AW = (N_NEURONS>1) ? $clog2(N_NEURONS) : 1
// - W          16      state/current word width, signed two's complement
// - FRAC       7       fractional bits (default Q9.7)
// - A          16'sh0003  recovery time scale a (0.02)
// - B          16'sh001A  recovery sensitivity b (0.2)
// - C          16'shDF80  post-spike v reset, also v reset value (-65.0)
// - D          16'sh0400  post-spike u increment (8.0)
// - VTH        16'sh0F00  spike threshold (30.0)
// - REFRAC     2       refractory length in steps (used only with IZH_REFRACTORY_EN)
// PORTS
// - clk          in   1       rising-edge clock
// - reset        in   1       async, active-high reset
// - step         in   1       start-sweep request, sampled when idle
// - busy         out  1       sweep in progress
// - done         out  1       one-cycle pulse: sweep complete, spikes valid
// - spikes       out  N       per-neuron spike flags of last sweep, held until next done
// - cur_wr_en    in   1       current write strobe
// - cur_wr_addr  in   AW      neuron index for current write
// - cur_wr_data  in   W       input current I (Q format)
// - rd_addr      in   AW      state read index
// - rd_v         out  W       v[rd_addr], combinational read
// - rd_u         out  W       u[rd_addr], combinational read
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-high.
// - Reset: v[i]=C, u[i]=0, I[i]=0, spikes=0, busy=0, done=0, FSM=IDLE, index=0; reset mid-sweep aborts it, no done.
// - FSM IDLE -> RUN on step (edge k); busy=1 from edge k. RUN updates neuron i at edge k+1+i.
// - RUN -> IDLE at edge k+N: last neuron written, spikes updated, done=1 for that one cycle, busy=0 same edge.
// - step while busy ignored (not queued); step in the done cycle accepted (FSM already IDLE).
// - mulq(x,y) = (x*y)>>>FRAC, 2W-bit signed product, arithmetic shift (floor). sat() clamps to [-2^(W-1), 2^(W-1)-1].
// - Intermediates at 2W+2 bits; saturation only at state write. K004=round(0.04*2^FRAC), K140=140<<FRAC.
// - Spike (v[i]>=VTH, signed): v<=C, u<=sat(u+D), spikes[i]=1.
// - Else: v<=sat(v + mulq(K004,mulq(v,v)) + 5*v + K140 - u + I[i]); u<=sat(u + mulq(A, mulq(B,v) - u)); spikes[i]=0.
// - u update uses pre-update v. Spike test uses v at start of this step (as in single-neuron core).
// - Current write: any time. Same-cycle write to neuron being updated: update uses old I, new I visible next step.
// - spikes vector assembled in shadow reg, copied to spikes only at done edge; spikes stable between dones.
// - rd_v/rd_u reflect committed state; valid any cycle.
// CONFIGURATION
// - IZH_REFRACTORY_EN defined: per-neuron counter ref[i]; on spike ref[i]<=REFRAC; while ref[i]!=0 the neuron holds
//   v=C, u unchanged, never spikes, ref[i] decrements once per step. Reset clears ref[i].
// - IZH_REFRACTORY_EN undefined: no counters, REFRAC ignored, update always follows equations above.
// TESTING
// - Reset: assert reset async mid-sweep -> rd_v=16'hDF80, rd_u=0 for all i, spikes=0, busy=0, no done.
// - I=0 all, step once -> busy 4 cycles, done at step+4, spikes=0, v[0] bit-exact vs golden model (below -65.0).
// - I[2]=16'h1400 (40.0), others 0, repeated steps -> spikes[2]=1 within 10 steps, next v[2]=16'hDF80, u[2]+=16'h0400; others 0.
// - I[1]=16'h7FFF -> v[1] clamps to 16'h7FFF (no wrap), spikes[1]=1 on following step.
// - step pulsed during busy -> ignored, exactly one done; cur write to neuron being updated -> old I used this step.
// - IZH_REFRACTORY_EN, REFRAC=2, I[0]=16'h1400 -> after spike v[0]=16'hDF80 held 2 steps, no spikes[0] for 2 steps.

Source files
------------

// File: rtl/izh_neuron_array.sv
// rtl/izh_neuron_array.sv - time-multiplexed Izhikevich neuron array; optional refractory counters via IZH_REFRACTORY_EN
module izh_neuron_array #(
  parameter int                  N_NEURONS = 4,
  parameter int                  W         = 16,
  parameter int                  FRAC      = 7,
  parameter logic signed [W-1:0] A         = 16'sh0003,
  parameter logic signed [W-1:0] B         = 16'sh001A,
  parameter logic signed [W-1:0] C         = 16'shDF80,
  parameter logic signed [W-1:0] D         = 16'sh0400,
  parameter logic signed [W-1:0] VTH       = 16'sh0F00,
  parameter int                  REFRAC    = 2,
  localparam int                 AW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step,
  output logic                 busy,
  output logic                 done,
  output logic [N_NEURONS-1:0] spikes,
  input  logic                 cur_wr_en,
  input  logic [AW-1:0]        cur_wr_addr,
  input  logic [W-1:0]         cur_wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [W-1:0]         rd_v,
  output logic [W-1:0]         rd_u
);

  // Intermediates carry two guard bits over the full product so nothing wraps before the final clamp.
  localparam int XW = 2 * W + 2;
  localparam logic signed [XW-1:0] SAT_HI = {{(XW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_LO = {{(XW - W + 1){1'b1}}, {(W - 1){1'b0}}};

  function automatic logic signed [XW-1:0] f_sx(input logic signed [W-1:0] x);
    return {{(XW - W){x[W-1]}}, x};
  endfunction

  function automatic logic signed [W-1:0] f_sat(input logic signed [XW-1:0] x);
    if (x > SAT_HI) return SAT_HI[W-1:0];
    if (x < SAT_LO) return SAT_LO[W-1:0];
    return x[W-1:0];
  endfunction

  // 0.04 rounded to the nearest code, 140.0 and the small-integer factor of the v equation
  localparam int                   K004   = (4 * (2 ** FRAC) + 50) / 100;
  localparam logic signed [XW-1:0] K004_X = XW'(K004);
  localparam logic signed [XW-1:0] K140_X = XW'(140 * (2 ** FRAC));
  localparam logic signed [XW-1:0] K5_X   = XW'(5);
  localparam logic signed [XW-1:0] A_X    = f_sx(A);
  localparam logic signed [XW-1:0] B_X    = f_sx(B);
  localparam logic signed [XW-1:0] D_X    = f_sx(D);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [AW-1:0]        r_idx;
  logic                 r_done;
  logic [N_NEURONS-1:0] r_shadow;
  logic [N_NEURONS-1:0] r_spikes;
  logic [N_NEURONS-1:0] w_shadow_nxt;
  logic                 w_upd;
  logic                 w_last;

  logic signed [W-1:0]  r_v [N_NEURONS];
  logic signed [W-1:0]  r_u [N_NEURONS];
  logic signed [W-1:0]  r_i [N_NEURONS];

  logic signed [XW-1:0] w_v_x, w_u_x, w_i_x;
  logic signed [XW-1:0] w_vv, w_t1, w_v_sum;
  logic signed [XW-1:0] w_bv, w_du, w_u_sum;
  logic                 w_fire;
  logic signed [W-1:0]  w_v_nxt, w_u_nxt;
  logic                 w_spk;

`ifdef IZH_REFRACTORY_EN
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  logic [RW-1:0] r_ref [N_NEURONS];
  logic [RW-1:0] w_ref_nxt;
  logic          w_hold;
`endif

  assign busy   = (r_state == S_RUN);
  assign done   = r_done;
  assign spikes = r_spikes;
  assign rd_v   = r_v[rd_addr];
  assign rd_u   = r_u[rd_addr];

  // Shared datapath operands for the neuron selected by the sweep index
  assign w_v_x   = f_sx(r_v[r_idx]);
  assign w_u_x   = f_sx(r_u[r_idx]);
  assign w_i_x   = f_sx(r_i[r_idx]);
  assign w_vv    = (w_v_x * w_v_x) >>> FRAC;
  assign w_t1    = (K004_X * w_vv) >>> FRAC;
  assign w_v_sum = w_v_x + w_t1 + (K5_X * w_v_x) + K140_X - w_u_x + w_i_x;
  assign w_bv    = (B_X * w_v_x) >>> FRAC;
  assign w_du    = (A_X * (w_bv - w_u_x)) >>> FRAC;
  assign w_u_sum = w_u_x + w_du;
  assign w_fire  = (r_v[r_idx] >= VTH);

  // Select the next v/u/spike for the current neuron: refractory hold, spike reset, or integration
  always_comb begin
    w_v_nxt = f_sat(w_v_sum);
    w_u_nxt = f_sat(w_u_sum);
    w_spk   = 1'b0;
`ifdef IZH_REFRACTORY_EN
    w_hold    = (r_ref[r_idx] != '0);
    w_ref_nxt = '0;
    if (w_hold) begin
      w_v_nxt   = C;
      w_u_nxt   = r_u[r_idx];
      w_ref_nxt = r_ref[r_idx] - RW'(1);
    end else if (w_fire) begin
      w_v_nxt   = C;
      w_u_nxt   = f_sat(w_u_x + D_X);
      w_spk     = 1'b1;
      w_ref_nxt = RW'(REFRAC);
    end
`else
    if (w_fire) begin
      w_v_nxt = C;
      w_u_nxt = f_sat(w_u_x + D_X);
      w_spk   = 1'b1;
    end
`endif
  end

  // Spike flag of the neuron being updated merged into the shadow vector
  always_comb begin
    w_shadow_nxt        = r_shadow;
    w_shadow_nxt[r_idx] = w_spk;
  end

  // Sweep FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Sweep FSM next state: a step is only honoured from idle
  always_comb begin
    w_state_nxt = r_state;
    w_upd       = 1'b0;
    w_last      = (r_idx == AW'(N_NEURONS - 1));
    case (r_state)
      S_IDLE: if (step) w_state_nxt = S_RUN;
      S_RUN: begin
        w_upd = 1'b1;
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Neuron index, done pulse and spike vector publication at the end of a sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_shadow <= '0;
      r_spikes <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_upd) begin
        r_shadow <= w_shadow_nxt;
        if (w_last) begin
          r_idx    <= '0;
          r_done   <= 1'b1;
          r_spikes <= w_shadow_nxt;
        end else begin
          r_idx <= r_idx + AW'(1);
        end
      end
    end
  end

  // Committed v/u state, one neuron written per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        r_v[n] <= C;
        r_u[n] <= '0;
      end
    end else if (w_upd) begin
      r_v[r_idx] <= w_v_nxt;
      r_u[r_idx] <= w_u_nxt;
    end
  end

  // Input currents, writable at any time; the datapath sees the old value on a same-cycle write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < N_NEURONS; n++) r_i[n] <= '0;
    end else if (cur_wr_en) begin
      r_i[cur_wr_addr] <= cur_wr_data;
    end
  end

`ifdef IZH_REFRACTORY_EN
  // Refractory counters, loaded on spike and counted down once per step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < N_NEURONS; n++) r_ref[n] <= '0;
    end else if (w_upd) begin
      r_ref[r_idx] <= w_ref_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_izh_neuron_array.sv
// tb/tb_izh_neuron_array.sv - self-checking bench for izh_neuron_array with an arithmetic reference model
module tb_izh_neuron_array;

  localparam int     N      = 4;
  localparam int     W      = 16;
  localparam int     FRAC   = 7;
  localparam int     AW     = 2;
  localparam int     REFRAC = 2;
  localparam longint PA     = 3;
  localparam longint PB     = 26;
  localparam longint PC     = -8320;
  localparam longint PD     = 1024;
  localparam longint PVTH   = 3840;
  localparam longint K004   = 5;
  localparam longint K140   = 17920;
`ifdef IZH_REFRACTORY_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          step;
  logic          busy;
  logic          done;
  logic [N-1:0]  spikes;
  logic          cur_wr_en;
  logic [AW-1:0] cur_wr_addr;
  logic [W-1:0]  cur_wr_data;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_v;
  logic [W-1:0]  rd_u;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  longint       mv   [N];
  longint       mu   [N];
  longint       mi   [N];
  int           mref [N];
  logic [N-1:0] mspk;

  izh_neuron_array dut (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .busy       (busy),
    .done       (done),
    .spikes     (spikes),
    .cur_wr_en  (cur_wr_en),
    .cur_wr_addr(cur_wr_addr),
    .cur_wr_data(cur_wr_data),
    .rd_addr    (rd_addr),
    .rd_v       (rd_v),
    .rd_u       (rd_u)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic longint sat(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic longint mulq(input longint x, input longint y);
    return (x * y) >>> FRAC;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = PC; mu[i] = 0; mi[i] = 0; mref[i] = 0;
    end
    mspk = '0;
  endtask

  task automatic model_sweep();
    longint v, u;
    for (int i = 0; i < N; i++) begin
      v = mv[i];
      u = mu[i];
      if (REF_EN && mref[i] != 0) begin
        mv[i] = PC;
        mref[i] = mref[i] - 1;
        mspk[i] = 1'b0;
      end else if (v >= PVTH) begin
        mv[i] = PC;
        mu[i] = sat(u + PD);
        mspk[i] = 1'b1;
        if (REF_EN) mref[i] = REFRAC;
      end else begin
        mv[i] = sat(v + mulq(K004, mulq(v, v)) + 5 * v + K140 - u + mi[i]);
        mu[i] = sat(u + mulq(PA, mulq(PB, v) - u));
        mspk[i] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [15:0] ev, eu;
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      #1;
      ev = mv[i][15:0];
      eu = mu[i][15:0];
      chk($sformatf("%s v[%0d]", tag, i), {16'h0, rd_v}, {16'h0, ev});
      chk($sformatf("%s u[%0d]", tag, i), {16'h0, rd_u}, {16'h0, eu});
    end
  endtask

  task automatic write_cur(input int a, input logic [15:0] d);
    @(negedge clk);
    cur_wr_en   = 1'b1;
    cur_wr_addr = AW'(a);
    cur_wr_data = d;
    @(posedge clk);
    #1;
    cur_wr_en = 1'b0;
    mi[a] = longint'($signed(d));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #3 reset = 1'b1;
    #4 reset = 1'b0;
    model_reset();
  endtask

  // One sweep; optionally a write to neuron inj_n plus a stray step while it is being updated
  task automatic sweep(input string tag, input bit inj, input int inj_n, input logic [15:0] inj_d);
    int d0;
    @(negedge clk);
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
    d0 = done_cnt;
    model_sweep();
    chk({tag, " busy@k"}, {31'h0, busy}, 32'h1);
    for (int c = 1; c <= N; c++) begin
      @(posedge clk);
      #1;
      if (inj && c == inj_n + 1) begin
        step = 1'b0;
        cur_wr_en = 1'b0;
      end
      if (c < N) begin
        chk($sformatf("%s busy@k+%0d", tag, c), {31'h0, busy}, 32'h1);
        chk($sformatf("%s done@k+%0d", tag, c), {31'h0, done}, 32'h0);
      end else begin
        chk({tag, " done@k+N"}, {31'h0, done}, 32'h1);
        chk({tag, " busy@k+N"}, {31'h0, busy}, 32'h0);
        chk({tag, " spikes"}, {28'h0, spikes}, {28'h0, mspk});
      end
      if (inj && c == inj_n) begin
        step        = 1'b1;
        cur_wr_en   = 1'b1;
        cur_wr_addr = AW'(inj_n);
        cur_wr_data = inj_d;
        mi[inj_n]   = longint'($signed(inj_d));
      end
    end
    check_state(tag);
    if (inj) begin
      repeat (N + 2) @(posedge clk);
      #1;
      chk({tag, " one done"}, done_cnt, d0 + 1);
      chk({tag, " idle after"}, {31'h0, busy}, 32'h0);
    end
  endtask

  initial begin
    logic [15:0] rnd;
    longint ub;
    int d0, seen;

    reset = 1'b1; step = 1'b0; cur_wr_en = 1'b0;
    cur_wr_addr = '0; cur_wr_data = '0; rd_addr = '0;
    model_reset();
    #25;
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst done", {31'h0, done}, 32'h0);
    chk("rst spikes", {28'h0, spikes}, 32'h0);
    check_state("rst");
    #10 reset = 1'b0;

    // Quiescent sweep: v[0] must fall below the reset potential
    sweep("zero", 1'b0, 0, 16'h0);
    rd_addr = 0;
    #1;
    chk("zero v0<C", {31'h0, ($signed(rd_v) < -16'sd8320)}, 32'h1);

    // Constant drive on neuron 2 must produce a spike with reset/increment
    write_cur(2, 16'h1400);
    seen = 0;
    for (int s = 0; s < 10 && seen == 0; s++) begin
      ub = mu[2];
      sweep($sformatf("drv%0d", s), 1'b0, 0, 16'h0);
      if (spikes[2] === 1'b1) begin
        seen = 1;
        rd_addr = 2;
        #1;
        chk("drv v2 reset", {16'h0, rd_v}, 32'h0000DF80);
        chk("drv u2 inc", {16'h0, rd_u}, {16'h0, 16'(ub + 1024)});
        chk("drv others", {28'h0, spikes & 4'b1011}, 32'h0);
      end
    end
    chk("drv spike within 10", seen, 1);

    // Randomised currents against the model
    for (int s = 0; s < 16; s++) begin
      rnd = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h1800));
      write_cur($urandom_range(0, N - 1), rnd);
      sweep($sformatf("rnd%0d", s), 1'b0, 0, 16'h0);
    end

    // Asynchronous reset in the middle of a sweep
    @(negedge clk);
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #2;
    model_reset();
    chk("mid rst busy", {31'h0, busy}, 32'h0);
    chk("mid rst done", {31'h0, done}, 32'h0);
    chk("mid rst spikes", {28'h0, spikes}, 32'h0);
    check_state("mid rst");
    d0 = done_cnt;
    #5 reset = 1'b0;
    repeat (N + 2) @(posedge clk);
    #1;
    chk("mid rst no done", done_cnt, d0);
    chk("mid rst idle", {31'h0, busy}, 32'h0);

    // Saturation in both directions, then a spike from the clamped maximum
    write_cur(1, 16'h8000);
    sweep("clampneg", 1'b0, 0, 16'h0);
    rd_addr = 1;
    #1;
    chk("clamp v1 min", {16'h0, rd_v}, 32'h00008000);
    write_cur(1, 16'h7FFF);
    sweep("clamppos", 1'b0, 0, 16'h0);
    rd_addr = 1;
    #1;
    chk("clamp v1 max", {16'h0, rd_v}, 32'h00007FFF);
    sweep("clampspk", 1'b0, 0, 16'h0);
    chk("clamp spike1", {31'h0, spikes[1]}, 32'h1);

    // Stray step and same-cycle current write while neuron 1 is being updated
    sweep("inj", 1'b1, 1, 16'h0A00);
    sweep("inj next", 1'b0, 0, 16'h0);

`ifdef IZH_REFRACTORY_EN
    pulse_reset();
    write_cur(0, 16'h1400);
    seen = 0;
    for (int s = 0; s < 10 && seen == 0; s++) begin
      sweep($sformatf("ref%0d", s), 1'b0, 0, 16'h0);
      if (spikes[0] === 1'b1) seen = 1;
    end
    chk("ref spike within 10", seen, 1);
    for (int s = 0; s < REFRAC; s++) begin
      sweep($sformatf("refhold%0d", s), 1'b0, 0, 16'h0);
      rd_addr = 0;
      #1;
      chk($sformatf("refhold%0d v0", s), {16'h0, rd_v}, 32'h0000DF80);
      chk($sformatf("refhold%0d spk0", s), {31'h0, spikes[0]}, 32'h0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
